// File: rtl/sort_floats_n_using_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sort_floats_n_using_fsm
// Description : N-element float bubble sort driving one shared external f_le
//               comparator per cycle, with early exit on a swap-free pass.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_floats_n_using_fsm #(
    parameter int FLEN = 64,
    parameter int N    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [0:N-1][FLEN-1:0] unsorted,
    input  logic                   descending,
    output logic                   valid_out,
    output logic [0:N-1][FLEN-1:0] sorted,
    output logic                   err,
    output logic                   busy,
    output logic [FLEN-1:0]        f_le_a,
    output logic [FLEN-1:0]        f_le_b,
    input  logic                   f_le_res,
    input  logic                   f_le_err
);
    localparam int              c_IW   = $clog2(N);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(N - 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SORT = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [0:N-1][FLEN-1:0]   r_w;
    logic [0:N-1][FLEN-1:0]   w_w_nxt;
    logic [0:N-1][FLEN-1:0]   r_sorted;
    logic [c_IW-1:0]          r_p;
    logic [c_IW-1:0]          r_i;
    logic [c_IW-1:0]          w_ip1;
    logic                     r_desc;
    logic                     r_swapped;
    logic                     r_valid_out;
    logic                     r_err;
    logic [FLEN-1:0]          w_lo;
    logic [FLEN-1:0]          w_hi;
    logic                     w_swap;
    logic                     w_any_swap;
    logic                     w_end_pass;
    logic                     w_done;

    // Pair under compare and the working array with this cycle's swap applied.
    always_comb begin
        w_ip1      = r_i + c_IW'(1);
        w_lo       = r_w[r_i];
        w_hi       = r_w[w_ip1];
        w_swap     = (r_state == S_SORT) && !f_le_res && !f_le_err;
        w_any_swap = r_swapped | w_swap;
        w_end_pass = (r_i == (c_LAST - r_p));
        w_done     = w_end_pass && ((r_p == c_LAST) || !w_any_swap);
        w_w_nxt    = r_w;
        if (w_swap) begin
            w_w_nxt[r_i]   = w_hi;
            w_w_nxt[w_ip1] = w_lo;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        f_le_a      = '0;
        f_le_b      = '0;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    w_state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                busy = 1'b1;
                // Descending order is ascending with the operands exchanged.
                f_le_a = r_desc ? w_hi : w_lo;
                f_le_b = r_desc ? w_lo : w_hi;
                if (f_le_err || w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_sorted    <= '0;
            r_p         <= '0;
            r_i         <= '0;
            r_desc      <= 1'b0;
            r_swapped   <= 1'b0;
            r_valid_out <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid_out <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        r_w       <= unsorted;
                        r_desc    <= descending;
                        r_p       <= '0;
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                    end
                end
                S_SORT: begin
                    r_w <= w_w_nxt;
                    if (f_le_err) begin
                        r_valid_out <= 1'b1;
                        r_err       <= 1'b1;
                        r_sorted    <= r_w;
                    end else if (w_done) begin
                        r_valid_out <= 1'b1;
                        r_sorted    <= w_w_nxt;
                    end else if (w_end_pass) begin
                        r_p       <= r_p + c_IW'(1);
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                    end else begin
                        r_i       <= w_ip1;
                        r_swapped <= w_any_swap;
                    end
                end
            endcase
        end
    end

    assign valid_out = r_valid_out;
    assign err       = r_err;
    assign sorted    = r_sorted;

endmodule
`default_nettype wire

// File: tb/tb_sort_floats_n_using_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_floats_n_using_fsm
// Description : Random and directed checks of the bubble sorter at N=2,4,5
//               against a rank-based stable-sort reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sort_floats_n_using_fsm;
    localparam int MAXN = 5;
    typedef logic [0:MAXN-1][63:0] vec_t;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic valid_in   = 1'b0;
    logic descending = 1'b0;
    vec_t vec        = '0;
    int   cur_n      = 4;
    int   n_checks   = 0;
    int   n_fail     = 0;

    always #5 clk = ~clk;

    // Low byte is a payload tag the comparator model ignores, so tagged ties compare equal.
    function automatic real key(input logic [63:0] x);
        return $bitstoreal({x[63:8], 8'h00});
    endfunction

    function automatic logic bad(input logic [63:0] x);
        return x[62:52] == 11'h7FF;
    endfunction

    logic vin_2, vo_2, err_2, busy_2, res_2, ferr_2;
    logic vin_4, vo_4, err_4, busy_4, res_4, ferr_4;
    logic vin_5, vo_5, err_5, busy_5, res_5, ferr_5;
    logic [0:1][63:0] srt_2;
    logic [0:3][63:0] srt_4;
    logic [0:4][63:0] srt_5;
    logic [63:0] a_2, b_2, a_4, b_4, a_5, b_5;

    assign vin_2  = valid_in && (cur_n == 2);
    assign vin_4  = valid_in && (cur_n == 4);
    assign vin_5  = valid_in && (cur_n == 5);
    assign res_2  = key(a_2) <= key(b_2);
    assign res_4  = key(a_4) <= key(b_4);
    assign res_5  = key(a_5) <= key(b_5);
    assign ferr_2 = bad(a_2) || bad(b_2);
    assign ferr_4 = bad(a_4) || bad(b_4);
    assign ferr_5 = bad(a_5) || bad(b_5);

    sort_floats_n_using_fsm #(.FLEN(64), .N(2)) u_dut_2 (
        .clk(clk), .rst(rst), .valid_in(vin_2), .unsorted(vec[0:1]),
        .descending(descending), .valid_out(vo_2), .sorted(srt_2), .err(err_2),
        .busy(busy_2), .f_le_a(a_2), .f_le_b(b_2), .f_le_res(res_2), .f_le_err(ferr_2));

    sort_floats_n_using_fsm #(.FLEN(64), .N(4)) u_dut_4 (
        .clk(clk), .rst(rst), .valid_in(vin_4), .unsorted(vec[0:3]),
        .descending(descending), .valid_out(vo_4), .sorted(srt_4), .err(err_4),
        .busy(busy_4), .f_le_a(a_4), .f_le_b(b_4), .f_le_res(res_4), .f_le_err(ferr_4));

    sort_floats_n_using_fsm #(.FLEN(64), .N(5)) u_dut_5 (
        .clk(clk), .rst(rst), .valid_in(vin_5), .unsorted(vec),
        .descending(descending), .valid_out(vo_5), .sorted(srt_5), .err(err_5),
        .busy(busy_5), .f_le_a(a_5), .f_le_b(b_5), .f_le_res(res_5), .f_le_err(ferr_5));

    logic         obs_valid, obs_err, obs_busy;
    vec_t         obs_sorted;
    logic [127:0] obs_ab;

    always_comb begin
        obs_valid  = 1'b0;
        obs_err    = 1'b0;
        obs_busy   = 1'b0;
        obs_sorted = '0;
        obs_ab     = '0;
        case (cur_n)
            2: begin
                obs_valid = vo_2; obs_err = err_2; obs_busy = busy_2;
                obs_sorted[0:1] = srt_2; obs_ab = {a_2, b_2};
            end
            4: begin
                obs_valid = vo_4; obs_err = err_4; obs_busy = busy_4;
                obs_sorted[0:3] = srt_4; obs_ab = {a_4, b_4};
            end
            default: begin
                obs_valid = vo_5; obs_err = err_5; obs_busy = busy_5;
                obs_sorted = srt_5; obs_ab = {a_5, b_5};
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL n=%0d %s: got %0h expected %0h", cur_n, tag, got, exp);
        end
    endtask

    // Stable sort by rank: strictly-before elements plus equal elements earlier in the input.
    function automatic vec_t model_sort(input vec_t v, input int n, input bit desc);
        vec_t r;
        int   rank;
        r = '0;
        for (int i = 0; i < n; i++) begin
            rank = 0;
            for (int j = 0; j < n; j++) begin
                if (desc ? (key(v[j]) > key(v[i])) : (key(v[j]) < key(v[i]))) rank++;
                else if (j < i && key(v[j]) == key(v[i])) rank++;
            end
            r[rank] = v[i];
        end
        return r;
    endfunction

    // Passes with swaps = largest count of out-of-order elements left of any element.
    function automatic int model_latency(input vec_t v, input int n, input bit desc);
        int worst, cnt, passes, comps;
        worst = 0;
        comps = 0;
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            for (int j = 0; j < i; j++)
                if (desc ? (key(v[j]) < key(v[i])) : (key(v[j]) > key(v[i]))) cnt++;
            if (cnt > worst) worst = cnt;
        end
        passes = (worst + 1 < n - 1) ? worst + 1 : n - 1;
        for (int p = 0; p < passes; p++) comps += n - 1 - p;
        return comps + 1;
    endfunction

    function automatic vec_t mkv(input real r0, input real r1, input real r2,
                                 input real r3, input real r4);
        vec_t v;
        v[0] = $realtobits(r0) | 64'd1;
        v[1] = $realtobits(r1) | 64'd2;
        v[2] = $realtobits(r2) | 64'd3;
        v[3] = $realtobits(r3) | 64'd4;
        v[4] = $realtobits(r4) | 64'd5;
        return v;
    endfunction

    // Drives a request at the current (negedge) time; returns in the valid_out cycle,
    // or one cycle later when a busy-time request pulse is injected.
    task automatic run_req(input string name, input vec_t v_in, input bit desc,
                           input bit expect_err, input bit ign);
        vec_t         v, exp_v;
        int           exp_lat, cyc;
        bit           busy_ok;
        logic [127:0] ab1;
        v = v_in;
        for (int i = cur_n; i < MAXN; i++) v[i] = '0;
        exp_v   = expect_err ? v : model_sort(v, cur_n, desc);
        exp_lat = expect_err ? 2 : model_latency(v, cur_n, desc);
        vec = v; descending = desc; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        cyc = 1; busy_ok = 1'b1; ab1 = obs_ab;
        while (1) begin
            if (ign) begin
                valid_in = (cyc == 1);
                if (cyc == 1) vec = ~v;
            end
            if (obs_valid || cyc >= 60) break;
            busy_ok &= obs_busy;
            @(negedge clk);
            cyc++;
        end
        check_eq({name, " latency"}, 320'(cyc), 320'(exp_lat));
        check_eq({name, " err"}, 320'(obs_err), 320'(expect_err));
        check_eq({name, " sorted"}, obs_sorted, exp_v);
        check_eq({name, " busy during sort"}, 320'(busy_ok), 320'(1));
        check_eq({name, " first operands"}, 320'(ab1),
                 320'(desc ? {v[1], v[0]} : {v[0], v[1]}));
        check_eq({name, " idle at result"}, 320'({obs_busy, obs_ab}), 320'(0));
        if (ign) begin
            @(negedge clk);
            check_eq({name, " ignored request"}, 320'({obs_busy, obs_valid}), 320'(0));
        end
    endtask

    task automatic reset_mid(input string name, input vec_t v_in);
        vec_t v;
        v = v_in;
        for (int i = cur_n; i < MAXN; i++) v[i] = '0;
        vec = v; descending = 1'b0; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq({name, " flags after reset"}, 320'({obs_busy, obs_valid, obs_err}), 320'(0));
        check_eq({name, " sorted after reset"}, obs_sorted, 320'(0));
        rst = 1'b0;
    endtask

    initial begin
        int   ns [3];
        vec_t v;
        ns = '{4, 2, 5};
        repeat (3) @(negedge clk);
        foreach (ns[k]) begin
            cur_n = ns[k];
            #1;
            check_eq("reset state", 320'({obs_valid, obs_err, obs_busy, obs_ab}), 320'(0));
            check_eq("reset sorted", obs_sorted, 320'(0));
        end
        rst = 1'b0;
        foreach (ns[k]) begin
            cur_n = ns[k];
            @(negedge clk);
            run_req("asc distinct", mkv(3.0, 1.0, 4.0, 2.0, 5.0), 1'b0, 1'b0, 1'b0);
            run_req("asc in order", mkv(1.0, 2.0, 3.0, 4.0, 5.0), 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < MAXN; i++) v[i] = $realtobits($itor(cur_n - i)) | 64'(i + 1);
            run_req("asc reversed", v, 1'b0, 1'b0, 1'b0);
            run_req("desc ties", mkv(2.0, -1.0, 2.0, 0.5, 2.0), 1'b1, 1'b0, 1'b0);
            v = mkv(1.0, 0.0, 0.0, 5.0, 3.0);
            v[1] = 64'h7FF8_0000_0000_0002;
            run_req("nan error", v, 1'b0, 1'b1, 1'b0);
            run_req("busy ignore", mkv(3.0, 1.0, 4.0, 2.0, 5.0), 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < MAXN; i++) v[i] = $realtobits($itor(cur_n - i)) | 64'(i + 1);
            reset_mid("reset mid-sort", v);
            run_req("after reset", mkv(3.0, 1.0, 4.0, 2.0, 5.0), 1'b1, 1'b0, 1'b0);
            for (int t = 0; t < 25; t++) begin
                bit e, d, ig;
                for (int i = 0; i < MAXN; i++)
                    v[i] = $realtobits(($itor($urandom_range(0, 8)) - 4.0) * 0.5)
                           | 64'($urandom_range(1, 255));
                e  = ($urandom_range(0, 7) == 0);
                d  = 1'($urandom_range(0, 1));
                ig = ($urandom_range(0, 3) == 0);
                if (e) v[$urandom_range(0, 1)] = $urandom_range(0, 1) ? 64'h7FF8_0000_0000_0011
                                                                    : 64'hFFF0_0000_0000_0000;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                run_req("random", v, d, e, ig);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort_floats_n_using_fsm.md
# sort_floats_n_using_fsm

Sorts a vector of N floating-point values in ascending or descending order using a multi-cycle bubble-sort FSM. Each cycle it drives one comparison through a single external shared `f_le` (a ≤ b) comparator. It replaces the fixed three-element sorter: N is a parameter, the sort direction is selectable per request, and sorting terminates early once a pass makes no swaps. It sits between the stimulus/register front end and the shared float-compare unit in the float-processing cluster.

## Interface
- `FLEN`, 64: float width in bits (IEEE-754 encoding as understood by the external comparator).
- `N`, 4: number of elements, N ≥ 2.
- `clk` input 1: clock.
- `rst` input 1: reset. Synchronous, active-high.
- `valid_in` input 1: request strobe. Accepted only while `busy`=0.
- `unsorted` input [0:N-1][FLEN-1:0]: operands. Captured on the accepted `valid_in` edge.
- `descending` input 1: sort direction. Captured with `unsorted`; 0 = ascending, 1 = descending.
- `valid_out` output 1: one-cycle result pulse.
- `sorted` output [0:N-1][FLEN-1:0]: result, registered. Holds its value until the next `valid_out`.
- `err` output 1: qualifies `valid_out`; 1 = comparator error, sort aborted.
- `busy` output 1: 1 while a sort is in progress.
- `f_le_a`, `f_le_b` output FLEN each: comparator operands.
- `f_le_res` input 1: combinational result, 1 when a ≤ b.
- `f_le_err` input 1: combinational comparator error (NaN/Inf operand); same cycle as the operands.

## Operation
- State lives in internal working array `w[0:N-1]`, pass counter `p` ($clog2(N) bits), index counter `i` ($clog2(N) bits) and a `swapped` flag. `p` and `i` use unsigned compares.
- FSM states:
  - IDLE: `busy`=0, `f_le_a`=`f_le_b`=0. On `valid_in`: load `w`←`unsorted`, latch `descending`, `p`←0, `i`←0, `swapped`←0, go to SORT.
  - SORT: one comparison per cycle on the pair (`w[i]`, `w[i+1]`).
    - Ascending: `f_le_a`=`w[i]`, `f_le_b`=`w[i+1]`; swap when `f_le_res`=0.
    - Descending: `f_le_a`=`w[i+1]`, `f_le_b`=`w[i]`; swap when `f_le_res`=0.
    - Equal elements are never swapped, so the sort is stable.
  - A swap sets `swapped`.
  - End of pass occurs when `i` = N-2-p.
    - Sort is done if `p` = N-2, or if no swap occurred in this pass (including the current compare).
    - Otherwise `p`←p+1, `i`←0, `swapped`←0.
  - When done: on the next edge, `sorted`←final `w` (including any swap from the last compare), `valid_out`←1, `err`←0, return to IDLE.
- Error handling: if `f_le_err`=1 in any SORT cycle, that compare's swap is not applied. On the next edge, `valid_out`←1, `err`←1, `sorted`←`w` as it stood (partially sorted), and the FSM returns to IDLE.
- `valid_in` while `busy`=1 is ignored; there is no queueing.
- `f_le_err` in IDLE is ignored.
- `busy` = (state == SORT).
- `err` is 0 whenever `valid_out` is 0.

## Timing
- Reset values: state IDLE, `valid_out`=0, `err`=0, `busy`=0, `sorted`=0, `w`=0, counters 0.
- Reset mid-sort aborts the sort immediately, with no `valid_out`.
- Let `valid_in` be sampled at edge 0.
  - SORT compare cycles run from edge 0 to edge C.
  - `valid_out` is high during the cycle after edge C (edge C registers the result). Latency is C+1 edges.
- Compare count C:
  - Minimum is N-1 (input already in order).
  - Maximum is N(N-1)/2. For N=4: 3 minimum, 6 maximum.
- A new `valid_in` is accepted in the same cycle that `valid_out` is high (the FSM is IDLE). The minimum issue interval is C+1 cycles.
- An error on compare k gives `valid_out`/`err` high during the cycle after edge k.

## Test plan
- Ascending, all distinct: N=4, {3.0, 1.0, 4.0, 2.0}, `descending`=0.
  - Required: `sorted`={1.0, 2.0, 3.0, 4.0}, `err`=0.
  - `busy` stays high from cycle 1 until `valid_out` goes high (C compares).
- Early termination:
  - {1.0, 2.0, 3.0, 4.0} ascending → `valid_out` 4 cycles after `valid_in`, output unchanged.
  - {4.0, 3.0, 2.0, 1.0} ascending → 7 cycles, output {1.0, 2.0, 3.0, 4.0}.
- Descending with ties: {2.0, -1.0, 2.0, 0.5}, `descending`=1.
  - Required: {2.0, 2.0, 0.5, -1.0}.
  - The two 2.0 values are tagged by distinct payload patterns; they must keep their input order.
- Comparator error: {1.0, NaN, 0.0, 5.0}.
  - Bench model asserts `f_le_err` on any NaN operand, which happens on the first compare.
  - Required: `valid_out`=1 and `err`=1 two cycles after `valid_in`. `busy` drops in that same cycle.
- Back-to-back and busy-ignore:
  - Pulse `valid_in` with a second vector while `busy`=1 → no effect.
  - Issue a new request in the `valid_out` cycle → accepted, with a correct second result.
- Reset mid-sort: assert `rst` on the 2nd compare cycle.
  - Required: next cycle `busy`=0, `valid_out`=0, `sorted`=0.
  - A subsequent request sorts correctly.
- Run each scenario at N=2 and N=5 as well.
